// File: rtl/accelerator_pkg.sv
// rtl/accelerator_pkg.sv - shared types and constants for the data memory responder
package accelerator_pkg;

  typedef enum logic {
    G_IDLE = 1'b0,
    G_WAIT = 1'b1
  } gnt_state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

  // Byte-lane merge: lanes with be set take new data, the rest keep the old word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// rtl/dmem_resp_pipe.sv - fixed-latency response shift pipeline, one valid+data per stage
module dmem_resp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_tvalid,
  input  logic [31:0] in_tdata,
  output logic        out_tvalid,
  output logic [31:0] out_tdata
);

  logic [DEPTH-1:0] vld_q;
  logic [31:0]      dat_q [DEPTH];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_tvalid;
      dat_q[0] <= in_tvalid ? in_tdata : 32'h0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_tvalid = vld_q[DEPTH-1];
  // Data is forced to zero whenever no response is presented.
  assign out_tdata  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : 32'h0;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - req/gnt/rvalid data memory with grant stalls and fixed response latency
// Optional bounds checking of addresses is enabled by macro DMEM_BOUNDS_CHECK_EN.
module data_mem_responder
  import accelerator_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          GNT_WAIT  = 0,
  parameter int          RESP_LAT  = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam logic [2:0]  GNT_WAIT_C = 3'(GNT_WAIT);

  gnt_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;

  assign accept = data_req_i & data_gnt_o;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= G_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = G_IDLE;
    cnt_d   = '0;
    if (data_req_i && !accept) begin
      state_d = G_WAIT;
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // In G_IDLE the counter is zero, so only a zero stall grants immediately.
  always_comb begin
    data_gnt_o = 1'b0;
    if (n_reset && data_req_i) begin
      data_gnt_o = (state_q == G_IDLE) ? (GNT_WAIT_C == 3'd0) : (cnt_q == GNT_WAIT_C);
    end
  end

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             unused_addr_bits;

  assign offset           = data_addr_i - BASE_ADDR;
  assign idx              = offset[IDX_W+1:2];
  assign unused_addr_bits = ^{offset[1:0], offset[31:IDX_W+2]};

`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_range = (data_addr_i >= BASE_ADDR) &&
                    ({2'b00, offset[31:2]} < 32'(MEM_WORDS));
`else
  assign in_range = 1'b1;
`endif

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (accept && data_we_i && in_range) begin
      mem[idx] <= be_merge(mem[idx], data_wdata_i, data_be_i);
    end
  end

  logic [31:0] resp_data;

  always_comb begin
    resp_data = 32'h0;
    if (!data_we_i) resp_data = in_range ? mem[idx] : DMEM_ERR_DATA;
  end

  dmem_resp_pipe #(
    .DEPTH (RESP_LAT)
  ) u_resp_pipe (
    .clk        (clk),
    .n_reset    (n_reset),
    .in_tvalid  (accept),
    .in_tdata   (resp_data),
    .out_tvalid (data_rvalid_o),
    .out_tdata  (data_rdata_o)
  );

endmodule
